mem_arbiter: RTL

Two-port arbiter that shares the single unified instruction/data memory between the multicycle CPU datapath (port 0) and the program loader / IO master (port 1). It issues at most one memory transaction per cycle, alternates fairly between simultaneous requesters, and supports locked sequences (e.g. loader bursts) with a bounded hold time. Read data returns one cycle after issue, with a valid strobe steered to the issuing port. It sits between the datapath memory interface (the address/write-data path driven under controller `i_or_d`/`mem_write`) and the synchronous RAM.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_pick2.sv | 16 +
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

    localparam logic [1:0] OWNER_FREE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    function automatic logic [1:0] owner_of(input state_t s);
        case (s)
            OWN0:    return OWNER_P0;
            OWN1:    return OWNER_P1;
            default: return OWNER_FREE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        if (&req) gnt = (last_gnt == PORT1) ? 2'b01 : 2'b10;
        else      gnt = req;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous RAM between the CPU datapath (port 0) and the loader
// (port 1): fair alternation, bounded lock tenures, 1-cycle read return.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             lock0,
    input  logic             lock1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [1:0]       owner
);

    localparam int              CNT_W      = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

    state_t           state;
    port_t            last_gnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             rd_pend;
    port_t            rd_port;

    logic [1:0] pick;
    logic [1:0] gnt;
    port_t      gnt_port;
    logic       gnt_lock;
    logic       own_lock;
    logic       other_req;

    rr_pick2 u_pick (
        .req      ({req1, req0}),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    // Grants are combinational so the command goes out in the request cycle;
    // reset gates them so nothing reaches the RAM while rst is low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt = 2'b00;
        case (state)
            IDLE:    gnt = pick;
            OWN0:    gnt = {1'b0, req0};
            OWN1:    gnt = {req1, 1'b0};
            default: gnt = 2'b00;
        endcase
        if (!rst) gnt = 2'b00;
    end

    assign gnt0      = gnt[0];
    assign gnt1      = gnt[1];
    assign gnt_port  = gnt[1] ? PORT1 : PORT0;
    assign gnt_lock  = gnt[1] ? lock1 : lock0;
    assign own_lock  = (state == OWN1) ? lock1 : lock0;
    assign other_req = (state == OWN1) ? req0 : req1;

    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt[1]) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_gnt <= PORT1;
            hold_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_port  <= PORT0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                rd_port  <= gnt_port;
                last_gnt <= gnt_port;
            end
            case (state)
                IDLE: begin
                    if (mem_en && gnt_lock) begin
                        state    <= (gnt_port == PORT1) ? OWN1 : OWN0;
                        hold_cnt <= CNT_W'(1);
                    end
                end
                OWN0, OWN1: begin
                    // Forced release honours the current grant; last_gnt = owner
                    // then hands the next tie to the waiting port.
                    if (mem_en) begin
                        if (!gnt_lock || (hold_cnt == HOLD_LIMIT && other_req)) begin
                            state    <= IDLE;
                            hold_cnt <= '0;
                        end else if (hold_cnt != HOLD_LIMIT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else if (!own_lock) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign rvalid0 = rd_pend && (rd_port == PORT0);
    assign rvalid1 = rd_pend && (rd_port == PORT1);
    assign rdata0  = mem_rdata;
    assign rdata1  = mem_rdata;
    assign owner   = owner_of(state);

endmodule
